video_sync_gen: RTL and testbench

Free-running raster timing generator that acts as the source end of the video sync interface: it drives the hs/vs/de/rgb stream consumed by the downstream line-effect and scaler stages. It produces pixel fetch coordinates for the core's renderer, accepts the returned pixel colour after a fixed pipeline latency, and emits colour, sync and data-enable aligned to each other. All outputs are registered and advance only on pixel clock-enable.

---
 rtl/video_sync_gen_pkg.sv | 42 ++++
 rtl/video_sync_gen_if.sv | 26 ++
 rtl/video_sync_gen_sync_delay.sv | 43 ++++
 rtl/video_sync_gen.sv | 133 +++++++++++++
 tb/tb_video_sync_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/video_sync_gen_pkg.sv
// Raster timing constants, counter width and total-length helpers shared by the
// video sync generator, its stream interface and its delay line.
package video_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_V_FP     = 8;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 27;
  localparam int DEF_PIPE     = 3;

  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  // Raw timing bits, active-high; output polarity is applied only at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic in_window(input cnt_t cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

endpackage

// File: rtl/video_sync_gen_if.sv
// Source-side video stream: fetch coordinates out, rendered colour back in,
// aligned colour/sync/data-enable and line/frame strobes out.
interface video_sync_gen_if;
  import video_timing_pkg::*;

  cnt_t        hcount;
  cnt_t        vcount;
  logic [23:0] rgb_in;
  logic [23:0] dout;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        line_start;
  logic        frame_start;

  modport master (
    output hcount, vcount, dout, hs_out, vs_out, de_out, line_start, frame_start,
    input  rgb_in
  );

  modport slave (
    input  hcount, vcount, dout, hs_out, vs_out, de_out, line_start, frame_start,
    output rgb_in
  );

endinterface

// File: rtl/video_sync_gen_sync_delay.sv
// DEPTH-stage shift register for the raw timing bits; advances only on ce and
// clears synchronously so a reset leaves no stale sync in flight.
module sync_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (ce_i) begin
      stage_d[0] = data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_sync_gen.sv
// Free-running raster generator: fetch counters, PIPE-delayed sync/de decode and
// colour capture aligned so hs/vs/de/dout all describe the same pixel.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE     = DEF_PIPE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  video_sync_gen_if.master vid
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
    $error("video_sync_gen: H_TOTAL exceeds the fetch counter range");
  end
  if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
    $error("video_sync_gen: V_TOTAL exceeds the fetch counter range");
  end
  if (PIPE < PIPE_MIN || PIPE > PIPE_MAX) begin : g_pipe_chk
    $error("video_sync_gen: PIPE outside 1..8");
  end

  cnt_t        hcount_q, hcount_d;
  cnt_t        vcount_q, vcount_d;
  logic [23:0] dout_q, dout_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic       h_wrap;
  logic       v_wrap;
  sync_bits_t raw;
  sync_bits_t delayed;

  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  // vs is decoded from vcount alone, so it changes exactly where vcount does: at hcount==0.
  assign raw.de = in_window(hcount_q, 0, H_ACTIVE) && in_window(vcount_q, 0, V_ACTIVE);
  assign raw.hs = in_window(hcount_q, HS_START, HS_END);
  assign raw.vs = in_window(vcount_q, VS_START, VS_END);

  sync_delay #(
    .DEPTH (PIPE),
    .WIDTH ($bits(sync_bits_t))
  ) u_sync_delay (
    .clk_i   (clk),
    .clr_n_i (reset_n),
    .ce_i    (ce_pix),
    .data_i  (raw),
    .data_o  (delayed)
  );

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    dout_d        = dout_q;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ce_pix) begin
      hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
      // rgb_in arriving now belongs to the same count as the delayed timing bits.
      de_d   = delayed.de;
      hs_d   = delayed.hs ? SYNC_ACT : SYNC_IDLE;
      vs_d   = delayed.vs ? SYNC_ACT : SYNC_IDLE;
      dout_d = delayed.de ? vid.rgb_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      dout_q        <= '0;
      de_q          <= 1'b0;
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      dout_q        <= dout_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.dout        = dout_q;
  assign vid.de_out      = de_q;
  assign vid.hs_out      = hs_q;
  assign vid.vs_out      = vs_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: a small-raster instance checked cycle by cycle against
// a tick-count raster model, plus a default-timing instance with positive syncs.
module tb_video_sync_gen;
  import video_timing_pkg::*;

  localparam int HT  = 8;
  localparam int VT  = 6;
  localparam int HA  = 4;
  localparam int VA  = 3;
  localparam int HS0 = 5;
  localparam int HS1 = 7;
  localparam int VS0 = 4;
  localparam int PA  = 2;

  localparam int BHT = 352;
  localparam int BVT = 262;
  localparam int BP  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, ce_a, rst_b_n, ce_b;

  video_sync_gen_if vif_a ();
  video_sync_gen_if vif_b ();

  video_sync_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0), .PIPE (2)
  ) dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .ce_pix  (ce_a),
    .vid     (vif_a)
  );

  video_sync_gen #(
    .SYNC_POL (1'b1)
  ) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .ce_pix  (ce_b),
    .vid     (vif_b)
  );

  int total = 0;
  int bad   = 0;
  int ta    = 0;
  bit last_ce_a = 1'b0;
  int tbt   = 0;
  int hs_high = 0;

  // Model: pixel index k counts ce ticks since reset; column k%HT, line (k/HT)%VT.
  function automatic bit a_de(input int k);
    return k >= 0 && (k % HT) < HA && ((k / HT) % VT) < VA;
  endfunction
  function automatic bit a_hs(input int k);
    return k >= 0 && (k % HT) >= HS0 && (k % HT) < HS1;
  endfunction
  function automatic bit a_vs(input int k);
    return k >= 0 && ((k / HT) % VT) == VS0;
  endfunction
  function automatic logic [23:0] a_pix(input int k);
    return {8'(k % HT), 8'((k / HT) % VT), 8'hA5};
  endfunction

  function automatic bit b_hs(input int k);
    return k >= 0 && (k % BHT) >= 272 && (k % BHT) < 304;
  endfunction
  function automatic bit b_vs(input int k);
    return k >= 0 && ((k / BHT) % BVT) >= 232 && ((k / BHT) % BVT) < 235;
  endfunction
  function automatic bit b_de(input int k);
    return k >= 0 && (k % BHT) < 256 && ((k / BHT) % BVT) < 224;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_a(input string sc);
    int k;
    k = ta - PA - 1;
    chk({sc, "/hcount"},      32'(vif_a.hcount),      32'(ta % HT));
    chk({sc, "/vcount"},      32'(vif_a.vcount),      32'((ta / HT) % VT));
    chk({sc, "/de_out"},      32'(vif_a.de_out),      32'(a_de(k)));
    chk({sc, "/hs_out"},      32'(vif_a.hs_out),      32'(!a_hs(k)));
    chk({sc, "/vs_out"},      32'(vif_a.vs_out),      32'(!a_vs(k)));
    chk({sc, "/dout"},        32'(vif_a.dout),        32'(a_de(k) ? a_pix(k) : 24'h0));
    chk({sc, "/line_start"},  32'(vif_a.line_start),  32'(last_ce_a && (ta % HT) == 0));
    chk({sc, "/frame_start"}, 32'(vif_a.frame_start), 32'(last_ce_a && (ta % (HT * VT)) == 0));
  endtask

  // Renderer stand-in: colour for pixel ta-PA is presented for the next tick; junk elsewhere.
  task automatic step_a(input bit rst_n, input bit ce, input string sc);
    rst_a_n = rst_n;
    ce_a    = ce;
    vif_a.rgb_in = (ta - PA >= 0 && a_de(ta - PA)) ? a_pix(ta - PA) : 24'($urandom);
    @(posedge clk);
    if (!rst_n) ta = 0;
    else if (ce) ta++;
    last_ce_a = rst_n && ce;
    #1;
    check_a(sc);
  endtask

  task automatic step_b(input bit rst_n);
    int k;
    rst_b_n = rst_n;
    ce_b    = 1'b1;
    vif_b.rgb_in = 24'($urandom);
    @(posedge clk);
    if (!rst_n) tbt = 0;
    else tbt++;
    #1;
    k = tbt - BP - 1;
    chk("pol1/hcount", 32'(vif_b.hcount), 32'(tbt % BHT));
    chk("pol1/hs_out", 32'(vif_b.hs_out), 32'(b_hs(k)));
    chk("pol1/vs_out", 32'(vif_b.vs_out), 32'(b_vs(k)));
    chk("pol1/de_out", 32'(vif_b.de_out), 32'(b_de(k)));
    if (k >= 0 && k < BHT && vif_b.hs_out === 1'b1) hs_high++;
  endtask

  initial begin
    bit ce_r;
    rst_a_n = 1'b0;
    ce_a    = 1'b0;
    rst_b_n = 1'b0;
    ce_b    = 1'b1;
    vif_a.rgb_in = '0;
    vif_b.rgb_in = '0;

    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, "reset");

    for (int i = 0; i < 100; i++) step_a(1'b1, 1'b1, "cont");

    step_a(1'b0, 1'b1, "ce3_rst");
    for (int i = 0; i < 160; i++) step_a(1'b1, (i % 3) == 2, "ce3");

    step_a(1'b0, 1'b1, "rand_rst");
    for (int i = 0; i < 200; i++) begin
      ce_r = 1'($urandom_range(0, 1));
      step_a(1'b1, ce_r, "rand_ce");
    end

    step_a(1'b0, 1'b1, "mid_init");
    for (int i = 0; i < 37; i++) step_a(1'b1, 1'b1, "mid_pre");
    step_a(1'b0, 1'b1, "mid_rst");
    for (int i = 0; i < 60; i++) step_a(1'b1, 1'b1, "mid_post");

    ce_a = 1'b0;
    for (int i = 0; i < 3; i++) step_b(1'b0);
    for (int i = 0; i < 3 * BHT + 8; i++) step_b(1'b1);
    chk("pol1/hs_width", 32'(hs_high), 32'd32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
